// File: rtl/spu_datapath.sv
// SPU datapath: 16-entry register file, ALU, write-back mux and zero detector.
// Executes the per-cycle control strobes issued by the SPU controller.
module spu_datapath #(
    parameter int DATA_W   = 16,
    parameter int RF_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rf_s1,
    input  logic              rf_s0,
    input  logic [3:0]        rf_w_addr,
    input  logic              rf_w_wr,
    input  logic [3:0]        rf_rp_addr,
    input  logic              rf_rp_rd,
    input  logic [3:0]        rf_rq_addr,
    input  logic              rf_rq_rd,
    input  logic              alu_s1,
    input  logic              alu_s0,
    input  logic [7:0]        loac,
    input  logic [DATA_W-1:0] dm_r_data,
    output logic [DATA_W-1:0] dm_w_data,
    output logic              pco_en
);

    logic [DATA_W-1:0] rf [RF_DEPTH];
    logic [DATA_W-1:0] rp_data;
    logic [DATA_W-1:0] rq_data;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] wb_data;

    // Reads are combinational and see the pre-edge contents: no write bypass.
    assign rp_data = rf_rp_rd ? rf[rf_rp_addr] : '0;
    assign rq_data = rf_rq_rd ? rf[rf_rq_addr] : '0;

    always_comb begin
        alu_result = rp_data;
        case ({alu_s1, alu_s0})
            2'b01:   alu_result = rp_data + rq_data;
            2'b10:   alu_result = rp_data - rq_data;
            default: alu_result = rp_data;
        endcase
    end

    always_comb begin
        wb_data = alu_result;
        case ({rf_s1, rf_s0})
            2'b01:   wb_data = dm_r_data;
            2'b10:   wb_data = {{(DATA_W-8){1'b0}}, loac};
            default: wb_data = alu_result;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_w_wr) begin
            rf[rf_w_addr] <= wb_data;
        end
    end

    assign dm_w_data = rp_data;
    assign pco_en    = (rp_data == '0);

endmodule

// File: tb/tb_spu_datapath.sv
// Bench for spu_datapath: instruction-level driver, directed vector table,
// hand sequences for reset and read-during-write, and randomized instruction streams.
module tb_spu_datapath;

    logic        clk;
    logic        rst;
    logic        rf_s1, rf_s0;
    logic [3:0]  rf_w_addr;
    logic        rf_w_wr;
    logic [3:0]  rf_rp_addr;
    logic        rf_rp_rd;
    logic [3:0]  rf_rq_addr;
    logic        rf_rq_rd;
    logic        alu_s1, alu_s0;
    logic [7:0]  loac;
    logic [15:0] dm_r_data;
    logic [15:0] dm_w_data;
    logic        pco_en;

    spu_datapath dut (
        .clk        (clk),
        .rst        (rst),
        .rf_s1      (rf_s1),
        .rf_s0      (rf_s0),
        .rf_w_addr  (rf_w_addr),
        .rf_w_wr    (rf_w_wr),
        .rf_rp_addr (rf_rp_addr),
        .rf_rp_rd   (rf_rp_rd),
        .rf_rq_addr (rf_rq_addr),
        .rf_rq_rd   (rf_rq_rd),
        .alu_s1     (alu_s1),
        .alu_s0     (alu_s0),
        .loac       (loac),
        .dm_r_data  (dm_r_data),
        .dm_w_data  (dm_w_data),
        .pco_en     (pco_en)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // MOVA/MOVB are register moves through the two "pass P" encodings.
    typedef enum int {OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_LOAC, OP_JMPZ, OP_MOVA, OP_MOVB} op_t;

    typedef struct {
        op_t         op;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic [7:0]  k;
        logic [15:0] dmr;
        logic [15:0] exp_dm;
        logic        exp_pco;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] model_rf [16];
    logic [15:0] exp_q [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input op_t op, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rc, input logic [7:0] k, input logic [15:0] dmr);
        {rf_s1, rf_s0, alu_s1, alu_s0} = 4'b0000;
        {rf_w_wr, rf_rp_rd, rf_rq_rd}  = 3'b000;
        rf_w_addr = ra; rf_rp_addr = 4'd0; rf_rq_addr = 4'd0;
        loac = k; dm_r_data = dmr;
        case (op)
            OP_LOAD:  begin rf_w_wr = 1'b1; rf_s0 = 1'b1; end
            OP_STORE: begin rf_rp_rd = 1'b1; rf_rp_addr = ra; end
            OP_JMPZ:  begin rf_rp_rd = 1'b1; rf_rp_addr = ra; end
            OP_LOAC:  begin rf_w_wr = 1'b1; rf_s1 = 1'b1; end
            OP_ADD, OP_SUB: begin
                rf_w_wr = 1'b1;
                rf_rp_rd = 1'b1; rf_rp_addr = rb;
                rf_rq_rd = 1'b1; rf_rq_addr = rc;
                alu_s0 = (op == OP_ADD);
                alu_s1 = (op == OP_SUB);
            end
            OP_MOVA: begin rf_w_wr = 1'b1; rf_rp_rd = 1'b1; rf_rp_addr = rb; end
            OP_MOVB: begin
                rf_w_wr = 1'b1; rf_rp_rd = 1'b1; rf_rp_addr = rb;
                rf_rq_rd = 1'b1; rf_rq_addr = rc;
                {alu_s1, alu_s0, rf_s1, rf_s0} = 4'b1111;
            end
            default: ;
        endcase
    endtask

    // Executes one instruction; the reference model tracks register contents by instruction meaning.
    task automatic do_instr(input op_t op, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [3:0] rc, input logic [7:0] k, input logic [15:0] dmr,
                            output logic [15:0] dm_seen, output logic pco_seen);
        logic [15:0] exp_dm;
        logic [15:0] new_val;
        logic        wr;
        drive(op, ra, rb, rc, k, dmr);
        case (op)
            OP_STORE, OP_JMPZ:         exp_dm = model_rf[ra];
            OP_ADD, OP_SUB, OP_MOVA, OP_MOVB: exp_dm = model_rf[rb];
            default:                   exp_dm = 16'h0000;
        endcase
        exp_q.push_back(exp_dm);
        #1;
        dm_seen  = dm_w_data;
        pco_seen = pco_en;
        begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check("sb_dm_w_data", dm_seen, e);
            check("sb_pco_en", {15'd0, pco_seen}, {15'd0, (e == 16'h0000)});
        end
        wr = 1'b1;
        case (op)
            OP_LOAD: new_val = dmr;
            OP_LOAC: new_val = {8'h00, k};
            OP_ADD:  new_val = 16'((32'(model_rf[rb]) + 32'(model_rf[rc])) % 65536);
            OP_SUB:  new_val = 16'((32'(model_rf[rb]) + 65536 - 32'(model_rf[rc])) % 65536);
            OP_MOVA, OP_MOVB: new_val = model_rf[rb];
            default: begin new_val = 16'h0000; wr = 1'b0; end
        endcase
        @(posedge clk);
        #1;
        if (wr) model_rf[ra] = new_val;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_rf[i] = 16'h0000;
    endtask

    initial begin
        vec_t        vecs [$];
        logic [15:0] dm_s;
        logic        pco_s;

        rst = 1'b1;
        drive(OP_STORE, 4'd0, 4'd0, 4'd0, 8'h00, 16'h0000);
        {rf_rp_rd, rf_w_wr} = 2'b00;
        model_clear();
        #1;
        check("reset_dm_idle", dm_w_data, 16'h0000);
        check("reset_pco_idle", {15'd0, pco_en}, 16'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors
        vecs.push_back('{OP_LOAC,  4'd1, 4'd0, 4'd0, 8'h05, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{OP_LOAC,  4'd2, 4'd0, 4'd0, 8'hFF, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{OP_ADD,   4'd3, 4'd1, 4'd2, 8'h00, 16'h0000, 16'h0005, 1'b0});
        vecs.push_back('{OP_STORE, 4'd3, 4'd0, 4'd0, 8'h00, 16'h0000, 16'h0104, 1'b0});
        vecs.push_back('{OP_STORE, 4'd2, 4'd0, 4'd0, 8'h00, 16'h0000, 16'h00FF, 1'b0});
        vecs.push_back('{OP_LOAC,  4'd1, 4'd0, 4'd0, 8'h00, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{OP_LOAC,  4'd2, 4'd0, 4'd0, 8'h01, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{OP_SUB,   4'd4, 4'd1, 4'd2, 8'h00, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{OP_STORE, 4'd4, 4'd0, 4'd0, 8'h00, 16'h0000, 16'hFFFF, 1'b0});
        vecs.push_back('{OP_ADD,   4'd5, 4'd4, 4'd2, 8'h00, 16'h0000, 16'hFFFF, 1'b0});
        vecs.push_back('{OP_STORE, 4'd5, 4'd0, 4'd0, 8'h00, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{OP_LOAD,  4'd7, 4'd0, 4'd0, 8'h00, 16'hBEEF, 16'h0000, 1'b1});
        vecs.push_back('{OP_STORE, 4'd7, 4'd0, 4'd0, 8'h00, 16'h0000, 16'hBEEF, 1'b0});
        vecs.push_back('{OP_JMPZ,  4'd4, 4'd0, 4'd0, 8'h00, 16'h0000, 16'hFFFF, 1'b0});
        vecs.push_back('{OP_JMPZ,  4'd0, 4'd0, 4'd0, 8'h00, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{OP_LOAC,  4'd8, 4'd0, 4'd0, 8'h07, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{OP_ADD,   4'd8, 4'd8, 4'd8, 8'h00, 16'h0000, 16'h0007, 1'b0});
        vecs.push_back('{OP_STORE, 4'd8, 4'd0, 4'd0, 8'h00, 16'h0000, 16'h000E, 1'b0});
        vecs.push_back('{OP_MOVA,  4'd9, 4'd7, 4'd0, 8'h00, 16'h0000, 16'hBEEF, 1'b0});
        vecs.push_back('{OP_MOVB,  4'd10, 4'd9, 4'd4, 8'h00, 16'h0000, 16'hBEEF, 1'b0});
        vecs.push_back('{OP_STORE, 4'd10, 4'd0, 4'd0, 8'h00, 16'h0000, 16'hBEEF, 1'b0});
        vecs.push_back('{OP_LOAC,  4'd6, 4'd0, 4'd0, 8'h11, 16'h0000, 16'h0000, 1'b1});
        foreach (vecs[i]) begin
            do_instr(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rc, vecs[i].k, vecs[i].dmr, dm_s, pco_s);
            check("tbl_dm_w_data", dm_s, vecs[i].exp_dm);
            check("tbl_pco_en", {15'd0, pco_s}, {15'd0, vecs[i].exp_pco});
        end

        // Read-during-write on r6: same-cycle read sees the old value
        drive(OP_LOAC, 4'd6, 4'd0, 4'd0, 8'h22, 16'h0000);
        rf_rp_rd = 1'b1; rf_rp_addr = 4'd6;
        #1;
        check("rdw_old_value", dm_w_data, 16'h0011);
        @(posedge clk);
        #1;
        model_rf[6] = 16'h0022;
        do_instr(OP_STORE, 4'd6, 4'd0, 4'd0, 8'h00, 16'h0000, dm_s, pco_s);
        check("rdw_new_value", dm_s, 16'h0022);

        // Reset mid-run: clears asynchronously and drops a pending write
        do_instr(OP_LOAD, 4'd3, 4'd0, 4'd0, 8'h00, 16'h1234, dm_s, pco_s);
        drive(OP_STORE, 4'd3, 4'd0, 4'd0, 8'h00, 16'h0000);
        #1;
        check("pre_rst_r3", dm_w_data, 16'h1234);
        rst = 1'b1;
        #1;
        check("async_rst_r3", dm_w_data, 16'h0000);
        check("async_rst_pco", {15'd0, pco_en}, 16'd1);
        drive(OP_LOAD, 4'd5, 4'd0, 4'd0, 8'h00, 16'h5555);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        for (int r = 0; r < 16; r++) begin
            do_instr(OP_STORE, 4'(r), 4'd0, 4'd0, 8'h00, 16'h0000, dm_s, pco_s);
            check("post_rst_read", dm_s, 16'h0000);
            check("post_rst_pco", {15'd0, pco_s}, 16'd1);
        end
        // Q port after reset: every r0 + rX lands as zero
        for (int r = 0; r < 16; r++) begin
            do_instr(OP_ADD, 4'd14, 4'd0, 4'(r), 8'h00, 16'h0000, dm_s, pco_s);
            do_instr(OP_STORE, 4'd14, 4'd0, 4'd0, 8'h00, 16'h0000, dm_s, pco_s);
            check("post_rst_q_read", dm_s, 16'h0000);
        end

        // Randomized instruction stream against the model
        for (int n = 0; n < 600; n++) begin
            op_t         op;
            logic [3:0]  ra, rb, rc;
            logic [15:0] dmr;
            op  = op_t'($urandom_range(0, 7));
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            rc  = ($urandom_range(0, 3) == 0) ? rb : 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       dmr = 16'h0000;
                1:       dmr = 16'hFFFF;
                default: dmr = 16'($urandom);
            endcase
            do_instr(op, ra, rb, rc, 8'($urandom), dmr, dm_s, pco_s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spu_datapath.md
# spu_datapath

Datapath for the SPU. It takes the per-cycle control strobes from the SPU controller and executes them. The block holds the 16-entry register file, the ALU, the write-back mux and the zero detector. It drives `pco_en` back to the controller and supplies `dm_w_data` to data memory.

## Interface
Parameters:
- `DATA_W`, default 16: register, ALU and memory data width.
- `RF_DEPTH`, default 16: number of registers, addressed by 4 bits.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `rf_s1`, `rf_s0`, in, 1 each: write-back mux select.
- `rf_w_addr`, in, 4: register file write address.
- `rf_w_wr`, in, 1: register file write enable.
- `rf_rp_addr`, in, 4: P-port read address.
- `rf_rp_rd`, in, 1: P-port read enable.
- `rf_rq_addr`, in, 4: Q-port read address.
- `rf_rq_rd`, in, 1: Q-port read enable.
- `alu_s1`, `alu_s0`, in, 1 each: ALU operation select.
- `loac`, in, 8: instruction constant field.
- `dm_r_data`, in, 16: data memory read data. This is a combinational read, valid in the same cycle as `dm_rd`.
- `dm_w_data`, out, 16: data memory write data, equal to `rp_data`.
- `pco_en`, out, 1: high when `rp_data` equals 0.

## Operation
Register file:
- `RF_DEPTH` x `DATA_W` flops.
- On `rst` all entries clear to 0 asynchronously.
- Write on the rising edge when `rf_w_wr`=1: `rf[rf_w_addr]` <= `wb_data`.

Read ports:
- Both ports are combinational.
- `rp_data` = `rf_rp_rd` ? `rf[rf_rp_addr]` : 0.
- `rq_data` = `rf_rq_rd` ? `rf[rf_rq_addr]` : 0.

ALU, on {`alu_s1`,`alu_s0`}:
- 00: pass `rp_data`.
- 01: `rp_data` + `rq_data`.
- 10: `rp_data` - `rq_data`.
- 11: pass `rp_data`.
- Results are modulo 2^16. There is no carry or overflow output.

Write-back mux, on {`rf_s1`,`rf_s0`}:
- 00: ALU result.
- 01: `dm_r_data`.
- 10: {8'h00, `loac`}, zero-extended.
- 11: ALU result.

Outputs:
- `pco_en` = (`rp_data` == 0), fully combinational.
- When `rf_rp_rd`=0, `rp_data` is 0, so `pco_en`=1. The controller only samples `pco_en` in the JMPZ state, where `rf_rp_rd`=1.
- `dm_w_data` = `rp_data`.

Per-instruction mapping (one execute cycle each):
- LOAD: `rf[ra]` <= `dm_r_data`.
- STORE: `dm_w_data` = `rf[ra]`.
- ADD: `rf[ra]` <= `rf[rb]` + `rf[rc]`.
- SUB: `rf[ra]` <= `rf[rb]` - `rf[rc]`.
- LOAC: `rf[ra]` <= `loac`.
- JMPZ: `pco_en` = (`rf[ra]` == 0).

## Timing
Reset values:
- All registers are 0.
- With all enables low: `dm_w_data`=0 and `pco_en`=1.

Latency:
- Reads are 0-cycle combinational.
- A write is visible on a read port from the cycle after the write edge.

Simultaneous events:
- Read and write to the same address in the same cycle: the read returns the old value. There is no bypass.
- A source and destination may be the same register (e.g. ADD r1,r1,r1). The result uses the old value and is written at the edge.
- Both ports may read the same address in the same cycle.

Reset mid-operation:
- Asserting `rst` during any cycle clears all registers immediately, regardless of `rf_w_wr`.
- A write pending on that edge is lost.

Wrap-around:
- 16'hFFFF + 1 = 0.
- 0 - 1 = 16'hFFFF.

Unused bits:
- Addresses are always in range because `RF_DEPTH`=16 with 4-bit addresses.
- `loac` bits above 8 do not exist.

## Test plan
- Reset: assert `rst` mid-run after writing r3=0x1234, then read r0..r15 on both ports → every read returns 0 and `pco_en`=1.
- LOAC+ADD: LOAC r1←0x05 and r2←0xFF, then ADD r3=r1+r2 with {`alu_s1`,`alu_s0`}=01 → r3 reads 0x0104. `loac`=0xFF writes 0x00FF, with no sign extension.
- SUB wrap: r1=0, r2=1, SUB r4=r1-r2 → r4 reads 0xFFFF. Then ADD r5=r4+r2 → r5 reads 0x0000.
- LOAD/STORE: `dm_r_data`=0xBEEF with `rf_s0`=1, write r7 → r7=0xBEEF. Next cycle P-read r7 → `dm_w_data`=0xBEEF.
- JMPZ zero detect: `rf_rp_rd`=1 on r4=0xFFFF → `pco_en`=0. On r0=0 → `pco_en`=1.
- Read-during-write: r6=0x0011, write r6←0x0022 while P-reading r6 in the same cycle → the same-cycle read returns 0x0011 and the next cycle returns 0x0022.
